// File: rtl/hack_mem_pkg.sv
// Shared types and constants for the Hack data-memory responder.
// The address map, the region decode and the screen FIFO entry layout live here.
package hack_mem_pkg;

  localparam logic [15:0] RAM_BASE    = 16'h0000;
  localparam logic [15:0] SCREEN_BASE = 16'h4000;
  localparam logic [15:0] KBD_ADDR    = 16'h6000;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SCREEN,
    REG_KBD,
    REG_NONE
  } mem_region_t;

  typedef struct packed {
    logic [12:0] offset;
    logic [15:0] data;
  } scr_entry_t;

  // Everything above the keyboard word is unmapped.
  function automatic mem_region_t decode_region(input logic [15:0] addr);
    mem_region_t region;
    region = REG_NONE;
    if (addr < SCREEN_BASE) begin
      region = REG_RAM;
    end else if (addr < KBD_ADDR) begin
      region = REG_SCREEN;
    end else if (addr == KBD_ADDR) begin
      region = REG_KBD;
    end
    return region;
  endfunction

endpackage

// File: rtl/hack_memory_scr_fifo.sv
// Synchronous FIFO of screen-write entries feeding the display controller.
// A push into a full FIFO is dropped unless a pop frees the slot in the same cycle.
module scr_fifo
  import hack_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  scr_entry_t push_entry_i,
  input  logic       pop_i,
  output scr_entry_t head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       overflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  scr_entry_t          mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                do_push;
  logic                do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign overflow_o = overflow_q;
  assign head_o     = empty_o ? '0 : mem_q[rd_ptr_q];

  // A simultaneous pop makes room, so a push into a full FIFO still lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
    if (push_i && !do_push) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

endmodule

// File: rtl/hack_memory.sv
// Hack M-side memory responder: data RAM, screen RAM and keyboard register with
// same-cycle reads, plus a FIFO mirroring every committed screen write.
module hack_memory
  import hack_mem_pkg::*;
#(
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] key_code,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_valid,
  input  logic        scr_ready,
  output logic        scr_overflow
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);

  logic [15:0]       ram_q [RAM_WORDS];
  logic [15:0]       scr_mem_q [SCREEN_WORDS];
  logic [15:0]       kbd_q;
  mem_region_t       region;
  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_idx;
  logic              wr_commit;
  logic              scr_push;
  logic              scr_pop;
  logic              fifo_full;
  logic              fifo_empty;
  scr_entry_t        push_entry;
  scr_entry_t        head_entry;

  assign region    = decode_region(addressM);
  assign ram_idx   = addressM[RAM_AW-1:0];
  assign scr_idx   = addressM[SCR_AW-1:0];
  assign wr_commit = writeM && !reset;
  assign key_ready = !reset;

  // Asynchronous read so M-operand instructions complete in a single cycle.
  always_comb begin
    inM = '0;
    case (region)
      REG_RAM:    inM = ram_q[ram_idx];
      REG_SCREEN: inM = scr_mem_q[scr_idx];
      REG_KBD:    inM = kbd_q;
      default:    inM = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_commit && region == REG_RAM) begin
      ram_q[ram_idx] <= outM;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_commit && region == REG_SCREEN) begin
      scr_mem_q[scr_idx] <= outM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_q <= '0;
    end else if (key_valid && key_ready) begin
      kbd_q <= key_code;
    end
  end

  assign scr_push          = wr_commit && region == REG_SCREEN;
  assign push_entry.offset = addressM[12:0];
  assign push_entry.data   = outM;
  assign scr_valid         = !fifo_empty;
  assign scr_pop           = scr_valid && scr_ready;
  assign scr_addr          = head_entry.offset;
  assign scr_data          = head_entry.data;

  scr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_scr_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (scr_push),
    .push_entry_i (push_entry),
    .pop_i        (scr_pop),
    .head_o       (head_entry),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .overflow_o   (scr_overflow)
  );

  // Full is implied by the FIFO's own push gating; exposed for debug visibility only.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_hack_memory.sv
// Randomised and directed bench for hack_memory with a queue-based reference model
// and a scoreboard monitor that checks every entry the display side consumes.
module tb_hack_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addressM, outM, key_code;
  logic        writeM, key_valid, scr_ready;
  logic [15:0] inM, scr_data;
  logic [12:0] scr_addr;
  logic        key_ready, scr_valid, scr_overflow;

  always #5 clk = ~clk;

  hack_memory dut (
    .clk(clk), .reset(reset), .addressM(addressM), .outM(outM), .writeM(writeM),
    .inM(inM), .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .scr_addr(scr_addr), .scr_data(scr_data), .scr_valid(scr_valid),
    .scr_ready(scr_ready), .scr_overflow(scr_overflow)
  );

  typedef struct {
    logic [12:0] off;
    logic [15:0] data;
  } ent_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  ent_t        exp_q[$];          // scoreboard: entries the display side must receive
  ent_t        mdl_q[$];          // model FIFO contents
  bit          mdl_ovf;
  logic [15:0] mdl_kbd;
  logic [15:0] mdl_mem[int];      // only addresses written since time zero

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a pop happens at the coming edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (scr_valid === 1'b1 && scr_ready === 1'b1) begin : mon
      ent_t e;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scr_pop_unexpected: got addr %h data %h expected no entry", scr_addr, scr_data);
      end else begin
        e = exp_q.pop_front();
        check("scr_addr", {19'd0, scr_addr}, {19'd0, e.off});
        check("scr_data", {16'd0, scr_data}, {16'd0, e.data});
        $display("pop  off=%h data=%h", scr_addr, scr_data);
      end
    end
  end

  // One transaction: drive, check combinational read, clock, update model, check state.
  task automatic step(input logic [15:0] a, input logic [15:0] d, input bit we,
                      input logic [15:0] kc, input bit kv, input bit sr, input bit rst);
    bit   pop, push;
    ent_t e;
    addressM = a; outM = d; writeM = we; key_code = kc; key_valid = kv;
    scr_ready = sr; reset = rst;
    #3;
    if (a < 16'h6000) begin
      if (mdl_mem.exists(int'(a))) check("inM", {16'd0, inM}, {16'd0, mdl_mem[int'(a)]});
    end else begin
      check("inM", {16'd0, inM}, (a == 16'h6000) ? {16'd0, mdl_kbd} : 32'd0);
    end
    check("key_ready", {31'd0, key_ready}, {31'd0, !rst});
    $display("txn  a=%h d=%h we=%0d kv=%0d sr=%0d rst=%0d inM=%h", a, d, we, kv, sr, rst, inM);
    @(posedge clk);
    if (rst) begin
      mdl_q.delete();
      exp_q.delete();
      mdl_ovf = 1'b0;
      mdl_kbd = '0;
    end else begin
      pop  = (mdl_q.size() > 0) && sr;
      push = we && a >= 16'h4000 && a < 16'h6000;
      if (we && a < 16'h6000) mdl_mem[int'(a)] = d;
      if (kv) mdl_kbd = kc;
      if (pop) void'(mdl_q.pop_front());
      if (push) begin
        e.off  = a[12:0];
        e.data = d;
        if (mdl_q.size() < 4) begin
          mdl_q.push_back(e);
          exp_q.push_back(e);
        end else begin
          mdl_ovf = 1'b1;
        end
      end
    end
    #1;
    check("scr_valid", {31'd0, scr_valid}, {31'd0, mdl_q.size() > 0});
    check("scr_overflow", {31'd0, scr_overflow}, {31'd0, mdl_ovf});
    if (mdl_q.size() == 0) check("scr_head_idle", {3'd0, scr_addr, scr_data}, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && mdl_q.size() > 0; i++) step(16'h0000, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    step(16'h0000, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    int          r;
    reset = 1'b1; addressM = '0; outM = '0; writeM = 1'b0;
    key_code = '0; key_valid = 1'b0; scr_ready = 1'b0;
    mdl_ovf = 1'b0; mdl_kbd = '0;
    @(posedge clk);
    #1;
    step(16'h0000, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(16'h0000, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    // Basic RAM write, read-during-write shows old value
    step(16'h0AA1, 16'h5555, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
    step(16'h0AA1, 16'h1234, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
    step(16'h0AA1, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

    // Keyboard update, ignored KBD write, unmapped read
    step(16'h6000, 16'h0000, 1'b0, 16'h0041, 1'b1, 1'b0, 1'b0);
    step(16'h6000, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(16'h6000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(16'h7FFF, 16'h1111, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(16'h7FFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Single screen write popped immediately
    step(16'h4000, 16'hFFFF, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
    step(16'h4000, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    step(16'h4000, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

    // Overflow with display stalled, then drain
    for (int i = 1; i <= 5; i++) step(16'h4000 + 16'(i), 16'(i), 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
    step(16'h4005, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    drain();

    // Push and pop together while full: no overflow, last entry delivered
    step(16'h0000, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(16'h4100 + 16'(i), 16'hC000 + 16'(i), 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
    step(16'h5FFF, 16'hAAAA, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
    drain();

    // Reset mid-drain while a RAM write is requested
    step(16'h0010, 16'h3333, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(16'h4200 + 16'(i), 16'h0B00 + 16'(i), 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
    step(16'h0000, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    step(16'h0010, 16'h7777, 1'b1, 16'h0, 1'b0, 1'b1, 1'b1);
    step(16'h0010, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    step(16'h0AA1, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);

    // Randomised traffic over a small working set so reads hit written words
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       a = 16'h0100 + 16'($urandom_range(0, 15));
      else if (r == 4) a = 16'h5FF8 + 16'($urandom_range(0, 7));
      else if (r < 7)  a = 16'h4000 + 16'($urandom_range(0, 7));
      else if (r == 7) a = 16'h6000;
      else             a = 16'($urandom_range(16'h6001, 16'hFFFF));
      step(a, 16'($urandom), ($urandom % 2) == 0, 16'($urandom), ($urandom % 4) == 0,
           ($urandom % 3) != 0, ($urandom % 50) == 0);
    end
    drain();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
